// File: rtl/lod_pkg.sv
// Shared constants, output-stage state type and the leading-one encoder
// used by the single LOD datapath in lod_rr_sched.
package lod_pkg;

    localparam int LOD_W  = 12;
    localparam int LOD_CW = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lod_out_st_t;

    // Returns {c, v}; an all-zero operand gives c=0, v=0, so only v separates it from 1.
    function automatic logic [LOD_CW:0] lod_enc(input logic [LOD_W-1:0] x);
        logic [LOD_CW-1:0] c;
        c = '0;
        for (int i = 0; i < LOD_W; i++) begin
            if (x[i]) c = LOD_CW'(i);
        end
        return {c, |x};
    endfunction

endpackage

// File: rtl/lod_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// found by scanning a doubled request vector so the wrap needs no modulo logic.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx
);

    logic [2*N-1:0] dbl;

    always_comb begin
        dbl = {req, req};
        gnt = '0;
        idx = '0;
        // Descending scan: the last hit kept is the lowest position inside the window.
        for (int j = 2*N-1; j >= 0; j--) begin
            if ((j >= int'(ptr)) && (j < int'(ptr) + N) && dbl[j]) begin
                gnt          = '0;
                gnt[j % N]   = 1'b1;
                idx          = IDW'(j % N);
            end
        end
    end

endmodule

// File: rtl/lod_rr_sched.sv
// Round-robin front end sharing one leading-one detector between N_REQ
// requesters, with a single registered result stage that drains in pass-through.
//
// state | meaning
// EMPTY | result register holds nothing, any grant is accepted
// FULL  | result valid; held stable until rsp_ready, new grant only on that cycle
module lod_rr_sched
    import lod_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = LOD_W,
    parameter int CW    = LOD_CW,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [CW-1:0]        rsp_c,
    output logic                 rsp_v
);

    lod_out_st_t     state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [CW-1:0]   c_q, c_d;
    logic            v_q, v_d;

    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             can_accept;
    logic             accept;
    logic [W-1:0]     op;
    logic [LOD_CW:0]  enc;

    rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign can_accept = (state_q == EMPTY) | rsp_ready;
    assign req_ready  = (can_accept && !rst) ? gnt : '0;
    assign accept     = |req_ready;
    assign op         = req_data[int'(gnt_idx)*W +: W];
    assign enc        = lod_enc(LOD_W'(op));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        c_d     = c_q;
        v_d     = v_q;
        if (accept) begin
            state_d = FULL;
            id_d    = gnt_idx;
            c_d     = CW'(enc[LOD_CW:1]);
            v_d     = enc[0];
            ptr_d   = (gnt_idx == IDW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            c_q     <= '0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = id_q;
    assign rsp_c     = c_q;
    assign rsp_v     = v_q;

endmodule

// File: tb/tb_lod_rr_sched.sv
// Directed bench for lod_rr_sched: reset, LOD encoding, round-robin order,
// backpressure, fairness and asynchronous reset while a result is pending.
module tb_lod_rr_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [47:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_c;
    logic        rsp_v;

    int checks;
    int errors;

    lod_rr_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
        .rsp_v     (rsp_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'hf;
        req_data  = '0;
        rsp_ready = 1'b1;
        step();
        step();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", rsp_valid); end
        checks++; if ({rsp_id, rsp_c, rsp_v} !== 7'd0) begin errors++; $display("FAIL reset_data: got id=%0d c=%0d v=%b exp 0/0/0", rsp_id, rsp_c, rsp_v); end
        checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d exp 0", dut.ptr_q); end
        req_valid = 4'b0000;
        rst       = 1'b0;
        #1;
    endtask

    task automatic test_single();
        req_valid       = 4'b0001;
        req_data[11:0]  = 12'h800;
        rsp_ready       = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b exp 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if ({rsp_valid, rsp_id, rsp_c, rsp_v} !== {1'b1, 2'd0, 4'd11, 1'b1})
            begin errors++; $display("FAIL single_rsp: got valid=%b id=%0d c=%0d v=%b exp 1/0/11/1", rsp_valid, rsp_id, rsp_c, rsp_v); end
        checks++; if (dut.ptr_q !== 2'd1) begin errors++; $display("FAIL single_ptr: got %0d exp 1", dut.ptr_q); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got valid=%b exp 0", rsp_valid); end
        checks++; if ({rsp_id, rsp_c, rsp_v} !== {2'd0, 4'd11, 1'b1}) begin errors++; $display("FAIL single_hold: got id=%0d c=%0d v=%b exp 0/11/1", rsp_id, rsp_c, rsp_v); end
    endtask

    task automatic test_zero_one();
        req_valid       = 4'b0010;
        req_data[23:12] = 12'h000;
        rsp_ready       = 1'b1;
        step();
        checks++; if ({rsp_valid, rsp_id, rsp_c, rsp_v} !== {1'b1, 2'd1, 4'd0, 1'b0})
            begin errors++; $display("FAIL zero_rsp: got valid=%b id=%0d c=%0d v=%b exp 1/1/0/0", rsp_valid, rsp_id, rsp_c, rsp_v); end
        req_data[23:12] = 12'h001;
        step();
        checks++; if ({rsp_valid, rsp_id, rsp_c, rsp_v} !== {1'b1, 2'd1, 4'd0, 1'b1})
            begin errors++; $display("FAIL one_rsp: got valid=%b id=%0d c=%0d v=%b exp 1/1/0/1", rsp_valid, rsp_id, rsp_c, rsp_v); end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_id [5];
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        pulse_reset();
        for (int i = 0; i < 4; i++) req_data[i*12 +: 12] = 12'h001 << (i + 4);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== (4'b0001 << exp_id[k])) begin errors++; $display("FAIL b2b_ready[%0d]: got %b exp %b", k, req_ready, 4'b0001 << exp_id[k]); end
            step();
            checks++; if ({rsp_valid, rsp_id, rsp_c, rsp_v} !== {1'b1, exp_id[k], 4'd4 + {2'b00, exp_id[k]}, 1'b1})
                begin errors++; $display("FAIL b2b_rsp[%0d]: got valid=%b id=%0d c=%0d v=%b exp 1/%0d/%0d/1", k, rsp_valid, rsp_id, rsp_c, rsp_v, exp_id[k], 4 + exp_id[k]); end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        req_valid       = 4'b0001;
        req_data[11:0]  = 12'h040;
        rsp_ready       = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_fill_ready: got %b exp 0001", req_ready); end
        step();
        req_valid       = 4'b0010;
        req_data[23:12] = 12'h00f;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b exp 0000", k, req_ready); end
            step();
            checks++; if ({rsp_valid, rsp_id, rsp_c, rsp_v} !== {1'b1, 2'd0, 4'd6, 1'b1})
                begin errors++; $display("FAIL bp_stall_rsp[%0d]: got valid=%b id=%0d c=%0d v=%b exp 1/0/6/1", k, rsp_valid, rsp_id, rsp_c, rsp_v); end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b exp 0010", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if ({rsp_valid, rsp_id, rsp_c, rsp_v} !== {1'b1, 2'd1, 4'd3, 1'b1})
            begin errors++; $display("FAIL bp_release_rsp: got valid=%b id=%0d c=%0d v=%b exp 1/1/3/1", rsp_valid, rsp_id, rsp_c, rsp_v); end
        step();
    endtask

    task automatic test_fairness();
        pulse_reset();
        req_data[11:0]  = 12'h003;
        req_data[35:24] = 12'h0a0;
        rsp_ready       = 1'b1;
        req_valid       = 4'b0101;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_first: got %b exp 0001", req_ready); end
        step();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL fair_second: got %b exp 0100", req_ready); end
        step();
        req_valid = 4'b0001;
        checks++; if ({rsp_id, rsp_c, rsp_v} !== {2'd2, 4'd7, 1'b1}) begin errors++; $display("FAIL fair_rsp: got id=%0d c=%0d v=%b exp 2/7/1", rsp_id, rsp_c, rsp_v); end
        checks++; if (dut.ptr_q !== 2'd3) begin errors++; $display("FAIL fair_ptr: got %0d exp 3", dut.ptr_q); end
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_wrap: got %b exp 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if ({rsp_id, rsp_c, rsp_v} !== {2'd0, 4'd1, 1'b1}) begin errors++; $display("FAIL fair_wrap_rsp: got id=%0d c=%0d v=%b exp 0/1/1", rsp_id, rsp_c, rsp_v); end
        step();
    endtask

    task automatic test_async_reset();
        req_valid       = 4'b0010;
        req_data[23:12] = 12'h100;
        rsp_ready       = 1'b0;
        step();
        checks++; if ({rsp_valid, rsp_id, rsp_c} !== {1'b1, 2'd1, 4'd8}) begin errors++; $display("FAIL arst_fill: got valid=%b id=%0d c=%0d exp 1/1/8", rsp_valid, rsp_id, rsp_c); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b exp 0", rsp_valid); end
        checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL arst_ptr: got %0d exp 0", dut.ptr_q); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL arst_ready: got %b exp 0000", req_ready); end
        #1;
        rst       = 1'b0;
        req_valid = 4'b1010;
        req_data[47:36] = 12'h002;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL arst_regrant: got %b exp 0010", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if ({rsp_valid, rsp_id, rsp_c, rsp_v} !== {1'b1, 2'd1, 4'd8, 1'b1})
            begin errors++; $display("FAIL arst_rsp: got valid=%b id=%0d c=%0d v=%b exp 1/1/8/1", rsp_valid, rsp_id, rsp_c, rsp_v); end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_zero_one();
        test_back_to_back();
        test_backpressure();
        test_fairness();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
